// File: rtl/controle_partida.sv
// controle_partida: game-round controller. Turns raw player-hit levels into
// single loss events, applies an invulnerability window after each loss,
// honours pause, and declares end of game once VIDAS losses have occurred.
//
// state        | meaning
// OCIOSO       | waiting for a start request, perdas held at 0
// JOGANDO      | round running, a new dano rise counts as a loss
// INVULNERAVEL | post-loss window, dano ignored, timer counts down
// FIM          | all lives lost, perdas held at VIDAS until restart
module controle_partida #(
    parameter int INV_CICLOS = 8,
    parameter int VIDAS      = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_iniciar,
    input  logic       i_dano,
    input  logic       i_pausa,
    output logic [1:0] o_perdas,
    output logic [1:0] o_estado,
    output logic       o_invulneravel,
    output logic       o_fim_jogo,
    output logic       o_pulso_dano
);

    localparam int TW = $clog2(INV_CICLOS + 1);
    // Loaded with INV_CICLOS-1 so that the zero check lands on the last
    // window cycle and the window lasts exactly INV_CICLOS cycles.
    localparam logic [TW-1:0] TIMER_CARGA = TW'(INV_CICLOS - 1);
    localparam logic [1:0]    VIDAS_MAX   = 2'(VIDAS);

    typedef enum logic [1:0] {
        OCIOSO       = 2'b00,
        JOGANDO      = 2'b01,
        INVULNERAVEL = 2'b10,
        FIM          = 2'b11
    } estado_t;

    estado_t       r_estado;
    logic [1:0]    r_perdas;
    logic [TW-1:0] r_timer;
    logic          r_pulso_dano;
    logic          r_iniciar_q;
    logic          r_dano_q;

    estado_t       w_estado_nxt;
    logic [1:0]    w_perdas_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_pulso_nxt;
    logic          w_iniciar_sub;
    logic          w_dano_sub;
    logic [1:0]    w_perdas_inc;

    assign w_iniciar_sub = i_iniciar & ~r_iniciar_q;
    assign w_dano_sub    = i_dano & ~r_dano_q;
    assign w_perdas_inc  = r_perdas + 2'd1;

    // State register plus the counters and edge-detect registers it owns.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_estado     <= OCIOSO;
            r_perdas     <= 2'd0;
            r_timer      <= '0;
            r_pulso_dano <= 1'b0;
            r_iniciar_q  <= 1'b0;
            r_dano_q     <= 1'b0;
        end else begin
            r_estado     <= w_estado_nxt;
            r_perdas     <= w_perdas_nxt;
            r_timer      <= w_timer_nxt;
            r_pulso_dano <= w_pulso_nxt;
            r_iniciar_q  <= i_iniciar;
            r_dano_q     <= i_dano;
        end
    end

    // Next-state, loss accounting and window timer.
    always_comb begin
        w_estado_nxt = r_estado;
        w_perdas_nxt = r_perdas;
        w_timer_nxt  = r_timer;
        w_pulso_nxt  = 1'b0;
        case (r_estado)
            OCIOSO: begin
                w_perdas_nxt = 2'd0;
                if (w_iniciar_sub) begin
                    w_estado_nxt = JOGANDO;
                end
            end
            JOGANDO: begin
                // A rise seen while paused is dropped, not deferred.
                if (w_dano_sub && !i_pausa) begin
                    w_perdas_nxt = w_perdas_inc;
                    w_pulso_nxt  = 1'b1;
                    if (w_perdas_inc == VIDAS_MAX) begin
                        w_estado_nxt = FIM;
                    end else begin
                        w_estado_nxt = INVULNERAVEL;
                        w_timer_nxt  = TIMER_CARGA;
                    end
                end
            end
            INVULNERAVEL: begin
                if (!i_pausa) begin
                    if (r_timer == '0) begin
                        w_estado_nxt = JOGANDO;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
            end
            FIM: begin
                w_perdas_nxt = VIDAS_MAX;
                if (w_iniciar_sub) begin
                    w_estado_nxt = JOGANDO;
                    w_perdas_nxt = 2'd0;
                    w_timer_nxt  = '0;
                end
            end
            default: begin
                w_estado_nxt = OCIOSO;
            end
        endcase
    end

    // Outputs decoded only from registers, never from inputs.
    always_comb begin
        o_estado       = r_estado;
        o_perdas       = r_perdas;
        o_pulso_dano   = r_pulso_dano;
        o_invulneravel = (r_estado == INVULNERAVEL);
        o_fim_jogo     = (r_estado == FIM);
    end

endmodule

// File: tb/tb_controle_partida.sv
// Testbench for controle_partida: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_controle_partida;

    localparam int INV = 4;
    localparam int VID = 3;

    logic       i_clock;
    logic       i_reset;
    logic       i_iniciar;
    logic       i_dano;
    logic       i_pausa;
    logic [1:0] o_perdas;
    logic [1:0] o_estado;
    logic       o_invulneravel;
    logic       o_fim_jogo;
    logic       o_pulso_dano;

    int n_chk  = 0;
    int n_fail = 0;

    controle_partida #(.INV_CICLOS(INV), .VIDAS(VID)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_iniciar     (i_iniciar),
        .i_dano        (i_dano),
        .i_pausa       (i_pausa),
        .o_perdas      (o_perdas),
        .o_estado      (o_estado),
        .o_invulneravel(o_invulneravel),
        .o_fim_jogo    (o_fim_jogo),
        .o_pulso_dano  (o_pulso_dano)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic       ini;
        logic       d;
        logic       p;
        logic [1:0] perdas;
        logic [1:0] estado;
        logic       pulso;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic ini, logic d, logic p,
                                logic [1:0] perdas, logic [1:0] estado, logic pulso);
        vec_t v;
        v.ini = ini; v.d = d; v.p = p;
        v.perdas = perdas; v.estado = estado; v.pulso = pulso;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int perdas, int estado, int pulso);
        chk({tag, " perdas"}, o_perdas, perdas);
        chk({tag, " estado"}, o_estado, estado);
        chk({tag, " pulso_dano"}, o_pulso_dano, pulso);
        chk({tag, " invulneravel"}, o_invulneravel, (estado == 2) ? 1 : 0);
        chk({tag, " fim_jogo"}, o_fim_jogo, (estado == 3) ? 1 : 0);
    endtask

    task automatic drive_cycle(logic ini, logic d, logic p);
        @(negedge i_clock);
        i_iniciar = ini; i_dano = d; i_pausa = p;
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b0; i_iniciar = 1'b0; i_dano = 1'b0; i_pausa = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
    endtask

    // Reference model: phase name, lives lost and cycles of window left.
    int m_fase;      // 0 idle, 1 playing, 2 window, 3 game over
    int m_perdas;
    int m_janela;
    int m_pulso;
    int m_ini_ant;
    int m_dano_ant;

    task automatic model_reset();
        m_fase = 0; m_perdas = 0; m_janela = 0; m_pulso = 0;
        m_ini_ant = 0; m_dano_ant = 0;
    endtask

    task automatic model_step(int ini, int d, int p);
        bit subida_ini, subida_dano;
        subida_ini  = (ini == 1) && (m_ini_ant == 0);
        subida_dano = (d == 1) && (m_dano_ant == 0);
        m_pulso = 0;
        if (m_fase == 0) begin
            if (subida_ini) m_fase = 1;
        end else if (m_fase == 1) begin
            if (subida_dano && p == 0) begin
                m_perdas = m_perdas + 1;
                m_pulso  = 1;
                if (m_perdas >= VID) m_fase = 3;
                else begin
                    m_fase   = 2;
                    m_janela = INV;
                end
            end
        end else if (m_fase == 2) begin
            if (p == 0) begin
                m_janela = m_janela - 1;
                if (m_janela == 0) m_fase = 1;
            end
        end else begin
            if (subida_ini) begin
                m_fase   = 1;
                m_perdas = 0;
            end
        end
        m_ini_ant  = ini;
        m_dano_ant = d;
    endtask

    initial begin
        int pulsos;
        i_reset = 1'b0; i_iniciar = 1'b0; i_dano = 1'b0; i_pausa = 1'b0;

        //           ini d  p  perdas estado pulso
        tbl[0]  = mk(0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 1, 0, 1, 2, 1);
        tbl[3]  = mk(0, 1, 0, 1, 2, 0);
        tbl[4]  = mk(0, 0, 0, 1, 2, 0);
        tbl[5]  = mk(0, 1, 0, 1, 2, 0);
        tbl[6]  = mk(0, 1, 0, 1, 1, 0);
        tbl[7]  = mk(0, 1, 0, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 1, 1, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 0);
        tbl[11] = mk(0, 1, 0, 2, 2, 1);
        tbl[12] = mk(0, 0, 1, 2, 2, 0);
        tbl[13] = mk(0, 0, 1, 2, 2, 0);
        tbl[14] = mk(0, 0, 1, 2, 2, 0);
        tbl[15] = mk(0, 0, 0, 2, 2, 0);
        tbl[16] = mk(0, 0, 0, 2, 2, 0);
        tbl[17] = mk(0, 0, 0, 2, 2, 0);
        tbl[18] = mk(0, 0, 0, 2, 1, 0);
        tbl[19] = mk(0, 1, 0, 3, 3, 1);
        tbl[20] = mk(0, 0, 0, 3, 3, 0);
        tbl[21] = mk(0, 1, 0, 3, 3, 0);
        tbl[22] = mk(1, 0, 0, 0, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 1, 0);

        #2;
        chk_all("reset", 0, 0, 0);
        @(negedge i_clock);
        i_reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive_cycle(tbl[i].ini, tbl[i].d, tbl[i].p);
            chk_all($sformatf("vec%0d", i), tbl[i].perdas, tbl[i].estado, tbl[i].pulso);
        end

        // Levels already high when reset releases: iniciar starts the round,
        // the simultaneous dano rise is ignored in OCIOSO.
        @(negedge i_clock);
        i_reset = 1'b0; i_iniciar = 1'b1; i_dano = 1'b1; i_pausa = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        chk_all("rel_alto", 0, 1, 0);
        drive_cycle(1, 1, 0);
        chk_all("rel_alto_held", 0, 1, 0);

        // dano held high for 20 cycles gives exactly one loss.
        drive_cycle(0, 0, 0);
        pulsos = 0;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(0, 1, 0);
            if (o_pulso_dano) pulsos++;
        end
        chk("held_pulsos", pulsos, 1);
        chk_all("held_end", 1, 1, 0);

        // Second loss, then asynchronous reset between edges mid-window.
        drive_cycle(0, 0, 0);
        drive_cycle(0, 1, 0);
        chk_all("pre_async", 2, 2, 1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("async perdas", o_perdas, 0);
        chk("async estado", o_estado, 0);
        chk("async invulneravel", o_invulneravel, 0);
        chk("async pulso_dano", o_pulso_dano, 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            int ini, d, p;
            ini = ($urandom_range(0, 11) == 0) ? 1 : 0;
            d   = ($urandom_range(0, 2) == 0) ? 1 : 0;
            p   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            @(negedge i_clock);
            i_iniciar = ini[0]; i_dano = d[0]; i_pausa = p[0];
            model_step(ini, d, p);
            @(posedge i_clock);
            #1;
            chk_all($sformatf("rand%0d", i), m_perdas, m_fase, m_pulso);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_partida.md
# controle_partida

Game-round controller that sequences the lives-lost counter. It turns the raw `dano` (player-hit) signal into single, debounced loss events. After each loss it applies an invulnerability window, supports pause, and declares end of game when the configured number of lives is exhausted. It sits between the input/collision logic and the score/display path, and drives the lives-lost value consumed by the display.

## Interface
- `INV_CICLOS`, default 8: invulnerability window length in clock cycles after a loss; legal range 1..255.
- `VIDAS`, default 3: losses that end the game; legal range 1..3.

- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `iniciar` in 1: start/restart request, level signal; acted on at its rising edge only.
- `dano` in 1: player-hit indication, level signal; acted on at its rising edge only.
- `pausa` in 1: level; while high, freezes the round.
- `perdas` out 2: lives lost so far, 0..VIDAS.
- `estado` out 2: current state encoding; 00 OCIOSO, 01 JOGANDO, 10 INVULNERAVEL, 11 FIM.
- `invulneravel` out 1: high exactly while `estado` is INVULNERAVEL.
- `fim_jogo` out 1: high exactly while `estado` is FIM.
- `pulso_dano` out 1: one-cycle pulse on every accepted loss.

## Operation
- **Reset** (reset=0, asynchronous):
  - estado=OCIOSO.
  - perdas=0.
  - pulso_dano=0.
  - Timer=0.
  - Edge registers for `iniciar` and `dano` are cleared to 0.
- **Edge detection:** each input is registered every cycle. A rise is `x & ~x_q`. A level held high produces exactly one event.
- **OCIOSO:** perdas held at 0. An `iniciar` rise moves to JOGANDO. `dano` and `pausa` are ignored.
- **JOGANDO:**
  - Ignored here: `iniciar` and a `dano` level that is held without a new rise.
  - A `dano` rise with pausa=0 is an accepted loss:
    - perdas ← perdas+1.
    - pulso_dano=1 for one cycle.
    - If the new perdas equals VIDAS → FIM.
    - Otherwise → INVULNERAVEL, with the timer loaded to INV_CICLOS−1.
  - A `dano` rise with pausa=1 is discarded and is not queued.
- **INVULNERAVEL:**
  - All `dano` activity is ignored; rises occurring here are lost.
  - With pausa=0: if timer=0 → JOGANDO, otherwise the timer decrements.
  - With pausa=1: the timer holds.
  - `iniciar` is ignored.
- **FIM:**
  - perdas holds at VIDAS.
  - An `iniciar` rise → JOGANDO with perdas=0 and timer=0, in one step.
  - `dano` and `pausa` are ignored.
- **Arithmetic:**
  - The timer is an unsigned counter of width ceil(log2(INV_CICLOS+1)).
  - perdas never wraps and never exceeds VIDAS.
- **Outputs:** all outputs are registered. No output is combinational from an input.

## Timing
- **Latency:** the input is sampled high at rising edge k, having been low at edge k−1. All resulting output changes become visible right after edge k.
- **Loss at edge k:**
  - pulso_dano is high from edge k to edge k+1.
  - invulneravel is high from edge k to edge k+INV_CICLOS, when pausa stays 0.
  - estado returns to JOGANDO after edge k+INV_CICLOS.
- **Pause inside the window:** every cycle with pausa=1 extends the window by one cycle.
- **Final loss:** the loss that makes perdas=VIDAS goes directly to FIM. No invulnerability window is applied.
- **Start from OCIOSO:** an `iniciar` rise at edge k gives estado=JOGANDO after edge k. A `dano` rise at the same edge k is ignored, because the state is OCIOSO when it is sampled.
- **Reset mid-operation:** outputs go to their reset values without waiting for a clock edge.
  - After reset is released, a level already high on `dano` or `iniciar` counts as a rise on the first edge.
  - It has no effect on `dano`, because OCIOSO ignores it.

## Test plan
- **Basic start and loss** (INV_CICLOS=4, VIDAS=3).
  - Stimulus: reset pulse, then an `iniciar` rise.
  - Then a `dano` rise at edge k.
  - Required: perdas=1 and pulso_dano high for one cycle after edge k.
  - invulneravel high for exactly 4 cycles; estado=01 after edge k+4.
- **Held `dano` and window masking.**
  - Stimulus: hold dano=1 for 20 cycles.
  - Then toggle `dano` twice inside the invulnerability window.
  - Required: perdas increments only once, and both toggles are ignored.
- **Saturation and end of game.**
  - Stimulus: three separated `dano` rises, each after the window expires.
  - Required: perdas goes 1, 2, 3; the third loss gives estado=11 and fim_jogo=1 with invulneravel=0.
  - A further `dano` rise leaves perdas=3.
- **Pause.**
  - Stimulus: pausa=1 for 3 cycles inside the window.
  - Required: invulneravel lasts 7 cycles in total.
  - A `dano` rise in JOGANDO with pausa=1 leaves perdas unchanged.
- **Restart from FIM.**
  - Stimulus: an `iniciar` rise while in FIM.
  - Required: estado=01 and perdas=0 after that edge; pulso_dano stays 0.
- **Asynchronous reset mid-window.**
  - Stimulus: drive reset=0 between clock edges while estado=10 with perdas=2.
  - Required: estado=00, perdas=0 and invulneravel=0 before the next edge.
